// File: rtl/ap_mult_pkg.sv
// Shared constants, types and helpers for the 12-bit approximate Wallace multiplier.
// Each partial-product bit index maps onto a column of the compressor tree.
package ap_mult_pkg;

  localparam int AP_WIDTH   = 12;
  localparam int AP_PP_BITS = AP_WIDTH * AP_WIDTH;
  localparam int AP_COLS    = 2 * AP_WIDTH - 1;

  typedef logic [AP_PP_BITS-1:0] pp_vec_t;

  // Bit idx = i*width + j holds b[i] & a[j], which belongs to column i+j.
  function automatic int pp_col(int idx, int width = AP_WIDTH);
    return (idx / width) + (idx % width);
  endfunction

endpackage

// File: rtl/ap_pp_gen_12b_if.sv
// Operand-in / partial-product-out handshake bundle of the partial-product stage.
// The slave modport is the stage itself; the master modport is its environment.
interface ap_pp_gen_12b_if
  import ap_mult_pkg::*;
#(
  parameter int WIDTH = AP_WIDTH
);

  logic [WIDTH-1:0]       a_i;
  logic [WIDTH-1:0]       b_i;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH*WIDTH-1:0] pp_o;
  logic                   out_valid;
  logic                   out_ready;

  modport slave (
    input  a_i,
    input  b_i,
    input  in_valid,
    output in_ready,
    output pp_o,
    output out_valid,
    input  out_ready
  );

  modport master (
    output a_i,
    output b_i,
    output in_valid,
    input  in_ready,
    input  pp_o,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/ap_skid_fifo2.sv
// Generic 2-entry valid/ready buffer; registered outputs, no input-to-output path.
// The head entry is shown on out_data, forced to zero while the buffer is empty.
module ap_skid_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] mem [2];
  logic          head;
  logic          tail;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign in_ready  = (count != 2'd2) && !rst;
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem[head] : '0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      // NOTE: the two entries are reset explicitly because in-flight data must
      // be discarded; a larger RAM-style store would normally be left unreset.
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= in_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ap_pp_gen_12b.sv
// Registered AND-array partial-product generator with optional low-column truncation,
// feeding the approximate-compressor tree through a 2-entry skid buffer.
module ap_pp_gen_12b
  import ap_mult_pkg::*;
#(
  parameter int WIDTH      = AP_WIDTH,
  parameter int TRUNC_COLS = 0
) (
  input logic                 clk,
  input logic                 rst,
  ap_pp_gen_12b_if.slave      bus
);

  localparam int PP = WIDTH * WIDTH;

  logic [PP-1:0] pp_next;

  // Truncated columns are constant zero, so their AND gates vanish at elaboration.
  for (genvar k = 0; k < PP; k++) begin : g_pp
    localparam int COL = pp_col(k, WIDTH);
    if (COL < TRUNC_COLS) begin : g_trunc
      assign pp_next[k] = 1'b0;
    end else begin : g_and
      assign pp_next[k] = bus.b_i[k / WIDTH] & bus.a_i[k % WIDTH];
    end
  end

  ap_skid_fifo2 #(
    .DW (PP)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (pp_next),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (bus.pp_o),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

endmodule

// File: tb/tb_ap_pp_gen_12b.sv
// Self-checking bench for ap_pp_gen_12b: directed and random traffic scored
// against a queue-based model of the buffered AND-array.
module tb_ap_pp_gen_12b;
  import ap_mult_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pp_vec_t q[$];

  ap_pp_gen_12b_if #(.WIDTH(AP_WIDTH)) bus ();
  ap_pp_gen_12b_if #(.WIDTH(AP_WIDTH)) bus_t ();

  ap_pp_gen_12b #(.WIDTH(AP_WIDTH), .TRUNC_COLS(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ap_pp_gen_12b #(.WIDTH(AP_WIDTH), .TRUNC_COLS(6)) dut_t (
    .clk (clk),
    .rst (rst),
    .bus (bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row i of the product array is either a copy of a or zero, selected by b[i].
  function automatic pp_vec_t ref_pp(logic [11:0] a, logic [11:0] b, int trunc);
    pp_vec_t     v;
    logic [11:0] row;
    v = '0;
    for (int i = 0; i < AP_WIDTH; i++) begin
      row = b[i] ? a : 12'h000;
      for (int j = 0; j < AP_WIDTH; j++)
        if (i + j < trunc) row[j] = 1'b0;
      v[i*AP_WIDTH +: AP_WIDTH] = row;
    end
    return v;
  endfunction

  task automatic check(string tag, logic [AP_PP_BITS-1:0] obs, logic [AP_PP_BITS-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all three outputs against the model's view of the buffer.
  task automatic check_outs(string tag);
    pp_vec_t exp_pp;
    exp_pp = (q.size() != 0 && !rst) ? q[0] : '0;
    check({tag, ".out_valid"}, AP_PP_BITS'(bus.out_valid), AP_PP_BITS'(q.size() != 0 && !rst));
    check({tag, ".in_ready"},  AP_PP_BITS'(bus.in_ready),  AP_PP_BITS'(q.size() != 2 && !rst));
    check({tag, ".pp_o"},      bus.pp_o, exp_pp);
  endtask

  // Advance one clock and update the model from what was presented before the edge.
  task automatic step();
    logic        push;
    logic        pop;
    logic [11:0] a;
    logic [11:0] b;
    push = bus.in_valid && (q.size() < 2) && !rst;
    pop  = bus.out_ready && (q.size() != 0) && !rst;
    a    = bus.a_i;
    b    = bus.b_i;
    @(posedge clk);
    #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(ref_pp(a, b, 0));
  endtask

  task automatic drive(logic v, logic [11:0] a, logic [11:0] b, logic rdy);
    bus.in_valid  = v;
    bus.a_i       = a;
    bus.b_i       = b;
    bus.out_ready = rdy;
  endtask

  initial begin
    pp_vec_t     first_bp;
    pp_vec_t     tpp;
    logic [11:0] ra;
    logic [11:0] rb;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 12'h0, 12'h0, 1'b0);
    bus_t.in_valid  = 1'b0;
    bus_t.a_i       = 12'h0;
    bus_t.b_i       = 12'h0;
    bus_t.out_ready = 1'b1;

    // Reset state.
    #3;
    check_outs("reset");
    check("reset.in_ready_low", AP_PP_BITS'(bus.in_ready), '0);
    #9;
    rst = 1'b0;
    #1;
    check_outs("post_reset");
    check("post_reset.in_ready", AP_PP_BITS'(bus.in_ready), AP_PP_BITS'(1));

    // Single pair, one-cycle latency, then pop.
    @(posedge clk);
    #1;
    drive(1'b1, 12'hFFF, 12'h001, 1'b0);
    step();
    drive(1'b0, 12'h0, 12'h0, 1'b1);
    check_outs("single");
    check("single.pp_const", bus.pp_o, AP_PP_BITS'(12'hFFF));
    step();
    check_outs("single.pop");

    // Streaming: 20 random back-to-back pairs, no bubbles.
    for (int n = 0; n < 20; n++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      drive(1'b1, ra, rb, 1'b1);
      step();
      check_outs("stream");
      check("stream.direct", bus.pp_o, ref_pp(ra, rb, 0));
      check("stream.valid", AP_PP_BITS'(bus.out_valid), AP_PP_BITS'(1));
    end
    drive(1'b0, 12'h0, 12'h0, 1'b1);
    step();
    check_outs("stream.drain");

    // Backpressure: fill with (3,5),(7,9); a third push is ignored.
    drive(1'b1, 12'd3, 12'd5, 1'b0);
    step();
    check_outs("bp.push1");
    drive(1'b1, 12'd7, 12'd9, 1'b0);
    step();
    check_outs("bp.push2");
    check("bp.full_ready", AP_PP_BITS'(bus.in_ready), '0);
    drive(1'b1, 12'd11, 12'd13, 1'b0);
    step();
    check_outs("bp.push3_ignored");
    check("bp.head", bus.pp_o, ref_pp(12'd3, 12'd5, 0));
    drive(1'b0, 12'h0, 12'h0, 1'b1);
    step();
    check_outs("bp.pop1");
    check("bp.second", bus.pp_o, ref_pp(12'd7, 12'd9, 0));
    check("bp.ready_back", AP_PP_BITS'(bus.in_ready), AP_PP_BITS'(1));
    step();
    check_outs("bp.pop2");

    // Simultaneous push/pop at count = 1.
    drive(1'b1, 12'h0A5, 12'h3C3, 1'b0);
    step();
    check_outs("pp1.fill");
    first_bp = ref_pp(12'h0A5, 12'h3C3, 0);
    check("pp1.head", bus.pp_o, first_bp);
    for (int n = 0; n < 4; n++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      drive(1'b1, ra, rb, 1'b1);
      step();
      check_outs("pp1.both");
      check("pp1.order", bus.pp_o, ref_pp(ra, rb, 0));
    end
    drive(1'b0, 12'h0, 12'h0, 1'b1);
    step();
    check_outs("pp1.drain");

    // Truncation instance: a=b=FFF, low 6 columns zero.
    bus_t.in_valid = 1'b1;
    bus_t.a_i      = 12'hFFF;
    bus_t.b_i      = 12'hFFF;
    @(posedge clk);
    #1;
    bus_t.in_valid = 1'b0;
    tpp = ref_pp(12'hFFF, 12'hFFF, 6);
    check("trunc.valid", AP_PP_BITS'(bus_t.out_valid), AP_PP_BITS'(1));
    check("trunc.pp", bus_t.pp_o, tpp);
    check("trunc.ones", AP_PP_BITS'($countones(bus_t.pp_o)), AP_PP_BITS'(123));
    @(posedge clk);
    #1;
    check("trunc.pop", AP_PP_BITS'(bus_t.out_valid), '0);

    // Reset mid-stream while full: outputs clear without a clock edge.
    drive(1'b1, 12'h123, 12'h456, 1'b0);
    step();
    drive(1'b1, 12'h789, 12'hABC, 1'b0);
    step();
    check_outs("midrst.full");
    drive(1'b0, 12'h0, 12'h0, 1'b0);
    rst = 1'b1;
    #2;
    q.delete();
    check_outs("midrst.async");
    check("midrst.pp_zero", bus.pp_o, '0);
    #2;
    rst = 1'b0;
    #1;
    check_outs("midrst.release");
    drive(1'b1, 12'd1, 12'd1, 1'b0);
    step();
    drive(1'b0, 12'h0, 12'h0, 1'b1);
    check_outs("midrst.fresh");
    check("midrst.pp1", bus.pp_o, AP_PP_BITS'(1));
    step();
    check_outs("midrst.pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
